// File: rtl/btb_2way_if.sv
// rtl/btb_2way_if.sv - lookup/update/counter bundle between fetch, resolve stage and the BTB
interface btb_2way_if;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        btb_hit;
    logic [65:0] btb_out;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic [1:0]  upd_type;
    logic        flush;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport master (
        output lookup_valid, lookup_pc, upd_valid, upd_pc, upd_target, upd_type, flush,
        input  btb_hit, btb_out, hit_count, miss_count
    );

    modport slave (
        input  lookup_valid, lookup_pc, upd_valid, upd_pc, upd_target, upd_type, flush,
        output btb_hit, btb_out, hit_count, miss_count
    );
endinterface

// File: rtl/btb_2way.sv
// rtl/btb_2way.sv - 2-way set-associative branch target buffer with per-set LRU and hit/miss counters
module btb_2way #(
    parameter int SETS = 16
) (
    input  logic        clk,
    input  logic        rst,
    btb_2way_if.slave   bus
);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = 30 - IDX;

    logic [SETS-1:0]  valid0, valid1;
    logic [SETS-1:0]  lru;
    logic [TAG_W-1:0] tag0 [SETS];
    logic [TAG_W-1:0] tag1 [SETS];
    logic [31:0]      tgt0 [SETS];
    logic [31:0]      tgt1 [SETS];
    logic [1:0]       typ0 [SETS];
    logic [1:0]       typ1 [SETS];
    logic [31:0]      hit_cnt, miss_cnt;

    logic [IDX-1:0]   l_set, u_set;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             l_hit0, l_hit1, l_hit;
    logic             u_match0, u_match1;
    logic             u_way;
    logic             u_go;
    logic             unused_pc_lsbs;

    assign l_set = bus.lookup_pc[IDX+1:2];
    assign l_tag = bus.lookup_pc[31:IDX+2];
    assign u_set = bus.upd_pc[IDX+1:2];
    assign u_tag = bus.upd_pc[31:IDX+2];
    assign unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    assign l_hit0 = valid0[l_set] && (tag0[l_set] == l_tag);
    assign l_hit1 = valid1[l_set] && (tag1[l_set] == l_tag);
    assign l_hit  = l_hit0 || l_hit1;

    always_comb begin
        bus.btb_out = '0;
        if (l_hit0)
            bus.btb_out = {l_tag, l_set, 2'b00, tgt0[l_set], typ0[l_set]};
        else if (l_hit1)
            bus.btb_out = {l_tag, l_set, 2'b00, tgt1[l_set], typ1[l_set]};
    end

    assign bus.btb_hit    = l_hit;
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;

    // Way choice: in-place match, then first free way, then the LRU victim.
    assign u_match0 = valid0[u_set] && (tag0[u_set] == u_tag);
    assign u_match1 = valid1[u_set] && (tag1[u_set] == u_tag);

    always_comb begin
        u_way = lru[u_set];
        if (u_match0)
            u_way = 1'b0;
        else if (u_match1)
            u_way = 1'b1;
        else if (!valid0[u_set])
            u_way = 1'b0;
        else if (!valid1[u_set])
            u_way = 1'b1;
    end

    assign u_go = bus.upd_valid && (bus.upd_type != 2'b11) && !bus.flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid0   <= '0;
            valid1   <= '0;
            lru      <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (bus.lookup_valid) begin
                if (l_hit)
                    hit_cnt <= hit_cnt + 32'd1;
                else
                    miss_cnt <= miss_cnt + 32'd1;
            end
            if (bus.flush) begin
                valid0 <= '0;
                valid1 <= '0;
                lru    <= '0;
            end else begin
                // Update is written last so its MRU choice overrides a same-set lookup hit.
                if (bus.lookup_valid && l_hit)
                    lru[l_set] <= !l_hit1 || l_hit0 ? 1'b1 : 1'b0;
                if (u_go) begin
                    lru[u_set] <= ~u_way;
                    if (u_way)
                        valid1[u_set] <= 1'b1;
                    else
                        valid0[u_set] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (u_go) begin
            if (u_way) begin
                tag1[u_set] <= u_tag;
                tgt1[u_set] <= bus.upd_target;
                typ1[u_set] <= bus.upd_type;
            end else begin
                tag0[u_set] <= u_tag;
                tgt0[u_set] <= bus.upd_target;
                typ0[u_set] <= bus.upd_type;
            end
        end
    end
endmodule

// File: tb/tb_btb_2way.sv
// tb/tb_btb_2way.sv - directed bench for btb_2way against a recency-stamp reference model
module tb_btb_2way;
    localparam int SETS = 16;

    logic clk;
    logic rst;
    btb_2way_if bus ();

    btb_2way #(.SETS(SETS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;
    bit chk_en;

    // Reference: each way holds a line PC and a last-use stamp; the older stamp is the victim.
    bit          m_valid [SETS][2];
    logic [31:0] m_pc    [SETS][2];
    logic [31:0] m_tgt   [SETS][2];
    logic [1:0]  m_typ   [SETS][2];
    longint      m_stamp [SETS][2];
    longint      m_time;
    logic [31:0] m_hits, m_misses;

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> 2) % SETS);
    endfunction

    function automatic void model_lookup(input logic [31:0] pc, output bit hit,
                                         output logic [65:0] out, output int way);
        int s;
        logic [31:0] line;
        s    = set_of(pc);
        line = {pc[31:2], 2'b00};
        hit  = 1'b0;
        out  = '0;
        way  = 0;
        for (int w = 1; w >= 0; w--) begin
            if (m_valid[s][w] && m_pc[s][w] == line) begin
                hit = 1'b1;
                way = w;
                out = {line, m_tgt[s][w], m_typ[s][w]};
            end
        end
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_stamp[s][w] = 0;
            end
        m_hits   = '0;
        m_misses = '0;
        m_time   = 0;
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset();
        end else begin
            bit          h;
            logic [65:0] o;
            int          hw, us, uw;
            logic [31:0] uline;
            model_lookup(bus.lookup_pc, h, o, hw);
            if (bus.lookup_valid) begin
                if (h) m_hits++;
                else   m_misses++;
            end
            if (bus.flush) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
            end else begin
                if (bus.lookup_valid && h)
                    m_stamp[set_of(bus.lookup_pc)][hw] = ++m_time;
                if (bus.upd_valid && bus.upd_type != 2'b11) begin
                    us    = set_of(bus.upd_pc);
                    uline = {bus.upd_pc[31:2], 2'b00};
                    uw    = -1;
                    for (int w = 1; w >= 0; w--)
                        if (m_valid[us][w] && m_pc[us][w] == uline) uw = w;
                    if (uw < 0)
                        for (int w = 1; w >= 0; w--)
                            if (!m_valid[us][w]) uw = w;
                    if (uw < 0)
                        uw = (m_stamp[us][0] < m_stamp[us][1]) ? 0 : 1;
                    m_valid[us][uw] = 1'b1;
                    m_pc[us][uw]    = uline;
                    m_tgt[us][uw]   = bus.upd_target;
                    m_typ[us][uw]   = bus.upd_type;
                    m_stamp[us][uw] = ++m_time;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit          h;
            logic [65:0] o;
            int          hw;
            model_lookup(bus.lookup_pc, h, o, hw);
            n_cmp += 4;
            if (bus.btb_hit !== h) begin
                n_bad++;
                $display("FAIL model_hit pc=%h got %b want %b", bus.lookup_pc, bus.btb_hit, h);
            end
            if (bus.btb_out !== o) begin
                n_bad++;
                $display("FAIL model_out pc=%h got %h want %h", bus.lookup_pc, bus.btb_out, o);
            end
            if (bus.hit_count !== m_hits) begin
                n_bad++;
                $display("FAIL model_hit_count got %0d want %0d", bus.hit_count, m_hits);
            end
            if (bus.miss_count !== m_misses) begin
                n_bad++;
                $display("FAIL model_miss_count got %0d want %0d", bus.miss_count, m_misses);
            end
        end
    end

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input bit lv, input logic [31:0] lpc, input bit uv,
                         input logic [31:0] upc, input logic [31:0] utgt,
                         input logic [1:0] utyp, input bit fl);
        @(posedge clk);
        #1;
        bus.lookup_valid = lv;
        bus.lookup_pc    = lpc;
        bus.upd_valid    = uv;
        bus.upd_pc       = upc;
        bus.upd_target   = utgt;
        bus.upd_type     = utyp;
        bus.flush        = fl;
        @(negedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc, input bit lv);
        drive(lv, pc, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] typ);
        drive(1'b0, 32'h0, 1'b1, pc, tgt, typ, 1'b0);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        chk_en = 1'b0;
        rst    = 1'b0;
        bus.lookup_valid = 1'b0;
        bus.lookup_pc    = '0;
        bus.upd_valid    = 1'b0;
        bus.upd_pc       = '0;
        bus.upd_target   = '0;
        bus.upd_type     = '0;
        bus.flush        = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        chk_en = 1'b1;

        look(32'h40, 1'b1);
        check("reset_hit", 66'(bus.btb_hit), 66'(0));
        check("reset_out", bus.btb_out, 66'h0);
        look(32'h0, 1'b0);
        check("first_miss_count", 66'(bus.miss_count), 66'(1));

        upd(32'h40, 32'h100, 2'b01);
        look(32'h40, 1'b1);
        check("jal_hit", 66'(bus.btb_hit), 66'(1));
        check("jal_out", bus.btb_out, {32'h40, 32'h100, 2'b01});
        look(32'h42, 1'b1);
        check("pc_lsb_ignored", bus.btb_out, {32'h40, 32'h100, 2'b01});

        upd(32'h80, 32'h180, 2'b00);
        look(32'h40, 1'b1);
        upd(32'hC0, 32'h300, 2'b10);
        look(32'h80, 1'b0);
        check("lru_evicted", 66'(bus.btb_hit), 66'(0));
        look(32'h40, 1'b0);
        check("mru_kept", bus.btb_out, {32'h40, 32'h100, 2'b01});
        look(32'hC0, 1'b0);
        check("jalr_type", bus.btb_out, {32'hC0, 32'h300, 2'b10});

        upd(32'h40, 32'h200, 2'b00);
        look(32'h40, 1'b0);
        check("in_place_out", bus.btb_out, {32'h40, 32'h200, 2'b00});
        look(32'hC0, 1'b1);
        check("no_dup_evict", 66'(bus.btb_hit), 66'(1));

        drive(1'b1, 32'h100, 1'b1, 32'h100, 32'h500, 2'b01, 1'b0);
        check("no_bypass", 66'(bus.btb_hit), 66'(0));
        look(32'h100, 1'b1);
        check("visible_next", bus.btb_out, {32'h100, 32'h500, 2'b01});
        upd(32'h140, 32'h600, 2'b11);
        look(32'h140, 1'b1);
        check("illegal_type", 66'(bus.btb_hit), 66'(0));

        upd(32'h104, 32'h700, 2'b00);
        upd(32'h208, 32'h800, 2'b01);
        upd(32'h3FC, 32'h900, 2'b10);
        drive(1'b1, 32'h104, 1'b1, 32'h180, 32'hA00, 2'b01, 1'b1);
        check("hit_during_flush", 66'(bus.btb_hit), 66'(1));
        look(32'h180, 1'b1);
        check("flush_drops_upd", 66'(bus.btb_hit), 66'(0));
        look(32'h104, 1'b1);
        check("flush_clears", 66'(bus.btb_hit), 66'(0));
        look(32'h3FC, 1'b1);
        check("flush_clears_last", 66'(bus.btb_hit), 66'(0));

        upd(32'h40, 32'h100, 2'b01);
        look(32'h40, 1'b1);
        check("pre_reset_hit", 66'(bus.btb_hit), 66'(1));
        #1;
        rst = 1'b0;
        #1;
        check("async_reset_hit", 66'(bus.btb_hit), 66'(0));
        check("async_reset_out", bus.btb_out, 66'h0);
        check("async_reset_hits", 66'(bus.hit_count), 66'(0));
        check("async_reset_misses", 66'(bus.miss_count), 66'(0));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        look(32'h40, 1'b1);
        check("post_reset_miss", 66'(bus.btb_hit), 66'(0));
        look(32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/btb_2way.md
Name: btb_2way

Overview:
- Branch target buffer for the fetch stage of the pipelined RV32I core.
- IF looks up the current fetch PC combinationally and gets a hit flag plus a btb_entry (pc, target_address, br_jal_jalr). These feed if_id_pipeline_reg.btb_hit/btb_out.
- The resolving stage writes back taken branch/jal/jalr outcomes through a registered update port.
- Organisation: 2-way set-associative, per-set LRU, plus hit/miss performance counters.

Parameters:
SETS, 16, number of sets; power of two, 2..256; IDX = log2(SETS)
TAG_W, 30-IDX, tag width = pc[31:IDX+2]

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
lookup_valid  in  1  IF lookup qualifier (fetch advancing, not stalled)
lookup_pc  in  32  fetch PC
btb_hit  out  1  combinational: lookup_pc matches a valid entry
btb_out  out  66  combinational btb_entry {pc[31:0], target_address[31:0], br_jal_jalr[1:0]}; all-zero on miss
upd_valid  in  1  write request from resolving stage
upd_pc  in  32  PC of resolved control-flow instruction
upd_target  in  32  resolved target address
upd_type  in  2  btb_ops: 00 br, 01 jal, 10 jalr; 11 illegal
flush  in  1  synchronous invalidate-all
hit_count  out  32  lookups with lookup_valid=1 that hit
miss_count  out  32  lookups with lookup_valid=1 that missed

Behaviour:
- Address split: set = pc[IDX+1:2], tag = pc[31:IDX+2]. pc[1:0] is ignored and stored as 00.
- Entry state per way: valid, tag, target[31:0], type[1:0]. Per set: one LRU bit naming the victim way.
- Reset (rst=0, async): all valid=0, all LRU=0 (victim way0), hit_count=0, miss_count=0. btb_hit=0 and btb_out=0 immediately.
- Lookup:
  - Pure combinational, 0-cycle latency. Tags are compared in both ways of set(lookup_pc).
  - On hit: btb_out = {tag, set, 2'b00, target, type} of the hit way.
  - If both ways match (must never happen), way0 wins.
  - btb_hit/btb_out are driven regardless of lookup_valid; lookup_valid only gates LRU and counter side effects.
- Lookup side effect: a hit with lookup_valid=1 at a clock edge sets that set's LRU to the other way (the hit way becomes MRU).
- Update (takes effect at the rising edge; visible to lookups the following cycle):
  - upd_type=11: request ignored, no state change.
  - If upd_pc tag matches a valid way in its set: overwrite target/type in place, never duplicate; that way becomes MRU.
  - Else if a way is invalid, allocate it (way0 preferred over way1): set valid, tag, target, type; it becomes MRU.
  - Else replace the LRU way; it becomes MRU.
- Same-cycle read/write: a lookup in the same cycle as an update returns pre-update contents (no bypass).
- LRU priority: if a lookup hit and an update hit the same set in one cycle, the update's LRU write wins.
- Flush:
  - Clears all valid bits and LRU bits at the edge.
  - Has priority over a same-cycle update (the update is dropped) and over lookup LRU side effects.
  - Counters still count the lookup of that cycle.
  - Does not clear counters.
- Counters: each lookup_valid=1 cycle increments exactly one of hit_count/miss_count by 1, based on combinational btb_hit. Both wrap modulo 2^32.
- Reset mid-operation: any in-flight update is lost; state returns to reset values without waiting for a clock.

Test Plan:
- Reset, then lookup_valid=1, lookup_pc=0x00000040 -> btb_hit=0, btb_out=0, miss_count=1 after the edge.
- Update pc=0x00000040, target=0x00000100, type=01; next cycle lookup 0x00000040 -> btb_hit=1, btb_out={0x00000040,0x00000100,01}. Lookup 0x00000042 -> same hit.
- Set conflict (SETS=16, all in set 0):
  - Insert 0x40 (way0), then 0x80 (way1); lookup 0x40 with lookup_valid=1; insert 0xC0 with type=10.
  - Required: 0x80 evicted (miss); 0x40 and 0xC0 hit, with 0xC0 returning type 10.
- Re-update 0x40 with target=0x00000200, type=00 -> lookup returns target 0x200, type 00. 0xC0 remains resident (no duplicate allocation, no eviction).
- Same cycle: update 0x100 and lookup 0x100 -> btb_hit=0 that cycle, 1 next cycle. In one cycle, update 0x140 with upd_type=11 -> no allocation, 0x140 misses.
- Fill several entries, then:
  - Assert flush together with an update to 0x180 -> all lookups miss afterwards, including 0x180; counters are retained.
  - Drive rst=0 mid-cycle -> btb_hit=0 and both counters 0 before the next clk edge.
